// File: rtl/oops_structs.sv
// ---------------------------------------------------------------------------
// oops_structs -- shared types for the out-of-order pipeline slice.
//
// Holds the ROB tag width, the ALU instruction encoding that travels through
// the reservation station untouched, and the reservation-station entry
// record used by alu_rs.
// ---------------------------------------------------------------------------
package oops_structs;

    localparam int ROB_TAG_W = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    // Operation descriptor handed from dispatch to the ALU.
    typedef struct packed {
        alu_op_e    op;
        logic [4:0] rd;
    } instruction_t;

    // FREE: slot unused, WAIT: at least one operand pending, READY: issuable.
    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2
    } rs_state_e;

    typedef struct packed {
        rs_state_e              state;
        instruction_t           inst;
        logic [31:0]            val1;
        logic [31:0]            val2;
        logic                   rdy1;
        logic                   rdy2;
        logic [ROB_TAG_W-1:0]   tag1;
        logic [ROB_TAG_W-1:0]   tag2;
        logic [ROB_TAG_W-1:0]   dest;
    } rs_entry_t;

endpackage

// File: rtl/prio_sel.sv
// ---------------------------------------------------------------------------
// prio_sel -- lowest-index priority selector.
//
// Ports:
//   req_i   [N-1:0]      request vector, one bit per candidate
//   valid_o              1 when any request bit is set
//   idx_o   [IDX_W-1:0]  index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module prio_sel #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs; otherwise a latch is inferred.
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs -- reservation station in front of a single ALU.
//
// Holds up to RS_DEPTH operations until both operands are known, snooping
// the common data bus for pending producer tags, and issues the lowest-index
// ready entry to the ALU. Issue outputs are driven from registered state
// only, so there is no combinational path from dispatch or CDB to issue.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   flush_i                            drop every entry (mispredict recovery)
//   disp_valid_i / disp_ready_o        dispatch handshake
//   disp_inst_i                        operation to store
//   disp_val{1,2}_i / disp_rdy{1,2}_i / disp_tag{1,2}_i
//                                      operand value, valid flag, producer tag
//   disp_dest_i                        ROB tag of the result
//   cdb_valid_i / cdb_tag_i / cdb_data_i
//                                      common data bus snoop
//   iss_valid_o / iss_ready_i          issue handshake toward the ALU
//   iss_inst_o / iss_val{1,2}_o / iss_dest_o
//                                      issued operation, operands, dest tag
//
// TAG_W is expected to equal ROB_TAG_W, since entries store tags in the
// shared rs_entry_t record.
// ---------------------------------------------------------------------------
module alu_rs
    import oops_structs::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int TAG_W    = oops_structs::ROB_TAG_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,

    input  logic               disp_valid_i,
    output logic               disp_ready_o,
    input  instruction_t       disp_inst_i,
    input  logic [31:0]        disp_val1_i,
    input  logic               disp_rdy1_i,
    input  logic [TAG_W-1:0]   disp_tag1_i,
    input  logic [31:0]        disp_val2_i,
    input  logic               disp_rdy2_i,
    input  logic [TAG_W-1:0]   disp_tag2_i,
    input  logic [TAG_W-1:0]   disp_dest_i,

    input  logic               cdb_valid_i,
    input  logic [TAG_W-1:0]   cdb_tag_i,
    input  logic [31:0]        cdb_data_i,

    output logic               iss_valid_o,
    input  logic               iss_ready_i,
    output instruction_t       iss_inst_o,
    output logic [31:0]        iss_val1_o,
    output logic [31:0]        iss_val2_o,
    output logic [TAG_W-1:0]   iss_dest_o
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry_t entries_q [RS_DEPTH];
    rs_entry_t entries_d [RS_DEPTH];

    logic [RS_DEPTH-1:0] free_vec;
    logic [RS_DEPTH-1:0] ready_vec;
    logic                free_any;
    logic                ready_any;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    ready_idx;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            free_vec[i]  = (entries_q[i].state == RS_FREE);
            ready_vec[i] = (entries_q[i].state == RS_READY);
        end
    end

    prio_sel #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_free_sel (
        .req_i   (free_vec),
        .valid_o (free_any),
        .idx_o   (free_idx)
    );

    prio_sel #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_ready_sel (
        .req_i   (ready_vec),
        .valid_o (ready_any),
        .idx_o   (ready_idx)
    );

    assign disp_ready_o = free_any;
    assign iss_valid_o  = ready_any;
    assign iss_inst_o   = entries_q[ready_idx].inst;
    assign iss_val1_o   = entries_q[ready_idx].val1;
    assign iss_val2_o   = entries_q[ready_idx].val2;
    assign iss_dest_o   = entries_q[ready_idx].dest;

    logic disp_fire;
    logic iss_fire;
    logic byp1;
    logic byp2;

    assign disp_fire = disp_valid_i & disp_ready_o;
    assign iss_fire  = iss_valid_o & iss_ready_i;
    assign byp1      = ~disp_rdy1_i & cdb_valid_i & (cdb_tag_i == disp_tag1_i);
    assign byp2      = ~disp_rdy2_i & cdb_valid_i & (cdb_tag_i == disp_tag2_i);

    // Later steps override earlier ones: wakeup, then issue, then dispatch,
    // then flush. Dispatch only targets an entry that is FREE in the
    // registered state, so it never collides with the issued entry.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (entries_q[i].state == RS_WAIT && cdb_valid_i) begin
                if (!entries_q[i].rdy1 && entries_q[i].tag1 == cdb_tag_i) begin
                    entries_d[i].val1 = cdb_data_i;
                    entries_d[i].rdy1 = 1'b1;
                end
                if (!entries_q[i].rdy2 && entries_q[i].tag2 == cdb_tag_i) begin
                    entries_d[i].val2 = cdb_data_i;
                    entries_d[i].rdy2 = 1'b1;
                end
                if (entries_d[i].rdy1 && entries_d[i].rdy2) begin
                    entries_d[i].state = RS_READY;
                end
            end
        end

        if (iss_fire) begin
            entries_d[ready_idx].state = RS_FREE;
        end

        if (disp_fire) begin
            entries_d[free_idx].inst  = disp_inst_i;
            entries_d[free_idx].val1  = byp1 ? cdb_data_i : disp_val1_i;
            entries_d[free_idx].val2  = byp2 ? cdb_data_i : disp_val2_i;
            entries_d[free_idx].rdy1  = disp_rdy1_i | byp1;
            entries_d[free_idx].rdy2  = disp_rdy2_i | byp2;
            entries_d[free_idx].tag1  = disp_tag1_i;
            entries_d[free_idx].tag2  = disp_tag2_i;
            entries_d[free_idx].dest  = disp_dest_i;
            entries_d[free_idx].state = ((disp_rdy1_i | byp1) && (disp_rdy2_i | byp2))
                                        ? RS_READY : RS_WAIT;
        end

        if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entries_d[i].state = RS_FREE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
            entries_q[i] <= entries_d[i];
            // NOTE: only the state field is reset; payload is meaningless while FREE.
            if (rst_i) begin
                entries_q[i].state <= RS_FREE;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs -- directed self-checking bench for alu_rs.
// ---------------------------------------------------------------------------
module tb_alu_rs;
    import oops_structs::*;

    localparam int TAG_W = ROB_TAG_W;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               flush_i = 1'b0;
    logic               disp_valid_i = 1'b0;
    logic               disp_ready_o;
    instruction_t       disp_inst_i = '0;
    logic [31:0]        disp_val1_i = '0;
    logic               disp_rdy1_i = 1'b0;
    logic [TAG_W-1:0]   disp_tag1_i = '0;
    logic [31:0]        disp_val2_i = '0;
    logic               disp_rdy2_i = 1'b0;
    logic [TAG_W-1:0]   disp_tag2_i = '0;
    logic [TAG_W-1:0]   disp_dest_i = '0;
    logic               cdb_valid_i = 1'b0;
    logic [TAG_W-1:0]   cdb_tag_i = '0;
    logic [31:0]        cdb_data_i = '0;
    logic               iss_valid_o;
    logic               iss_ready_i = 1'b0;
    instruction_t       iss_inst_o;
    logic [31:0]        iss_val1_o;
    logic [31:0]        iss_val2_o;
    logic [TAG_W-1:0]   iss_dest_o;

    int n_cmp = 0;
    int n_err = 0;

    alu_rs #(.RS_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .disp_valid_i (disp_valid_i),
        .disp_ready_o (disp_ready_o),
        .disp_inst_i  (disp_inst_i),
        .disp_val1_i  (disp_val1_i),
        .disp_rdy1_i  (disp_rdy1_i),
        .disp_tag1_i  (disp_tag1_i),
        .disp_val2_i  (disp_val2_i),
        .disp_rdy2_i  (disp_rdy2_i),
        .disp_tag2_i  (disp_tag2_i),
        .disp_dest_i  (disp_dest_i),
        .cdb_valid_i  (cdb_valid_i),
        .cdb_tag_i    (cdb_tag_i),
        .cdb_data_i   (cdb_data_i),
        .iss_valid_o  (iss_valid_o),
        .iss_ready_i  (iss_ready_i),
        .iss_inst_o   (iss_inst_o),
        .iss_val1_o   (iss_val1_o),
        .iss_val2_o   (iss_val2_o),
        .iss_dest_o   (iss_dest_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_disp(input alu_op_e op, input logic [31:0] v1, input logic r1,
                              input logic [TAG_W-1:0] t1, input logic [31:0] v2,
                              input logic r2, input logic [TAG_W-1:0] t2,
                              input logic [TAG_W-1:0] dest);
        disp_valid_i   = 1'b1;
        disp_inst_i.op = op;
        disp_inst_i.rd = 5'(dest);
        disp_val1_i    = v1;
        disp_rdy1_i    = r1;
        disp_tag1_i    = t1;
        disp_val2_i    = v2;
        disp_rdy2_i    = r2;
        disp_tag2_i    = t2;
        disp_dest_i    = dest;
    endtask

    task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic [31:0] d);
        cdb_valid_i = v;
        cdb_tag_i   = t;
        cdb_data_i  = d;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_cmp++;
        if (disp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_disp_ready: got %0b want 1", disp_ready_o);
        end
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_iss_valid: got %0b want 0", iss_valid_o);
        end
    endtask

    task automatic test_basic();
        iss_ready_i = 1'b1;
        drive_disp(OP_ADD, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3);
        step();
        disp_valid_i = 1'b0;
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_val1_o !== 32'd5 || iss_val2_o !== 32'd7 ||
            iss_dest_o !== 4'd3 || iss_inst_o.op !== OP_ADD) begin
            n_err++;
            $display("FAIL basic_issue: got v=%0b a=%0d b=%0d d=%0d op=%0d want 1 5 7 3 0",
                     iss_valid_o, iss_val1_o, iss_val2_o, iss_dest_o, iss_inst_o.op);
        end
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b0 || disp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL basic_drain: got v=%0b r=%0b want 0 1", iss_valid_o, disp_ready_o);
        end
    endtask

    task automatic test_wakeup();
        iss_ready_i = 1'b1;
        drive_disp(OP_SUB, 32'd0, 1'b0, 4'd2, 32'd9, 1'b1, 4'd0, 4'd4);
        step();
        disp_valid_i = 1'b0;
        cdb(1'b1, 4'd3, 32'hDEAD);  // non-matching tag must not wake
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL wake_wait0: got %0b want 0", iss_valid_o);
        end
        step();
        cdb(1'b1, 4'd2, 32'h10);
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL wake_wait1: got %0b want 0", iss_valid_o);
        end
        step();
        cdb(1'b0, 4'd0, 32'd0);
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_val1_o !== 32'h10 || iss_val2_o !== 32'd9 ||
            iss_dest_o !== 4'd4 || iss_inst_o.op !== OP_SUB) begin
            n_err++;
            $display("FAIL wake_issue: got v=%0b a=%0h b=%0h d=%0d want 1 10 9 4",
                     iss_valid_o, iss_val1_o, iss_val2_o, iss_dest_o);
        end
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL wake_drain: got %0b want 0", iss_valid_o);
        end
    endtask

    task automatic test_bypass();
        iss_ready_i = 1'b1;
        drive_disp(OP_XOR, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6, 4'd5);
        cdb(1'b1, 4'd6, 32'hAB);
        step();
        disp_valid_i = 1'b0;
        cdb(1'b0, 4'd0, 32'd0);
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_val1_o !== 32'd1 || iss_val2_o !== 32'hAB ||
            iss_dest_o !== 4'd5) begin
            n_err++;
            $display("FAIL bypass_issue: got v=%0b a=%0h b=%0h d=%0d want 1 1 ab 5",
                     iss_valid_o, iss_val1_o, iss_val2_o, iss_dest_o);
        end
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL bypass_drain: got %0b want 0", iss_valid_o);
        end
    endtask

    task automatic test_full();
        logic [TAG_W-1:0] want;
        iss_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_disp(OP_OR, 32'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'(i));
            step();
        end
        n_cmp++;
        if (disp_ready_o !== 1'b0) begin
            n_err++; $display("FAIL full_ready: got %0b want 0", disp_ready_o);
        end
        drive_disp(OP_OR, 32'd99, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd9);
        step();
        disp_valid_i = 1'b0;
        n_cmp++;
        if (disp_ready_o !== 1'b0 || iss_dest_o !== 4'd0) begin
            n_err++; $display("FAIL full_ignore: got r=%0b d=%0d want 0 0", disp_ready_o, iss_dest_o);
        end
        iss_ready_i = 1'b1;
        step();
        n_cmp++;
        if (disp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL full_reopen: got %0b want 1", disp_ready_o);
        end
        // Remaining entries drain in order; the ignored dispatch (dest 9) must never appear.
        for (int i = 1; i < 4; i++) begin
            want = 4'(i);
            n_cmp++;
            if (iss_valid_o !== 1'b1 || iss_dest_o !== want || iss_val1_o !== 32'(i)) begin
                n_err++;
                $display("FAIL full_drain%0d: got v=%0b d=%0d want 1 %0d", i, iss_valid_o, iss_dest_o, want);
            end
            step();
        end
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL full_empty: got v=%0b d=%0d want 0", iss_valid_o, iss_dest_o);
        end
    endtask

    task automatic test_priority();
        iss_ready_i = 1'b0;
        drive_disp(OP_AND, 32'hA0, 1'b1, 4'd0, 32'hA1, 1'b1, 4'd0, 4'd10);
        step();
        drive_disp(OP_AND, 32'd0, 1'b0, 4'd5, 32'hB1, 1'b1, 4'd0, 4'd11);
        step();
        drive_disp(OP_AND, 32'hC0, 1'b1, 4'd0, 32'hC1, 1'b1, 4'd0, 4'd12);
        step();
        disp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (iss_valid_o !== 1'b1 || iss_dest_o !== 4'd10 || iss_val1_o !== 32'hA0) begin
                n_err++;
                $display("FAIL prio_hold%0d: got v=%0b d=%0d a=%0h want 1 10 a0", i, iss_valid_o, iss_dest_o, iss_val1_o);
            end
            step();
        end
        iss_ready_i = 1'b1;
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_dest_o !== 4'd12 || iss_val1_o !== 32'hC0) begin
            n_err++; $display("FAIL prio_second: got v=%0b d=%0d want 1 12", iss_valid_o, iss_dest_o);
        end
        step();
        cdb(1'b1, 4'd5, 32'h55);
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL prio_waiting: got %0b want 0", iss_valid_o);
        end
        step();
        cdb(1'b0, 4'd0, 32'd0);
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_dest_o !== 4'd11 || iss_val1_o !== 32'h55 || iss_val2_o !== 32'hB1) begin
            n_err++;
            $display("FAIL prio_woken: got v=%0b d=%0d a=%0h b=%0h want 1 11 55 b1",
                     iss_valid_o, iss_dest_o, iss_val1_o, iss_val2_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        iss_ready_i = 1'b1;
        drive_disp(OP_SLT, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd1);
        step();
        drive_disp(OP_SLT, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd2);
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_dest_o !== 4'd2 || iss_val1_o !== 32'd3) begin
            n_err++; $display("FAIL b2b_first: got v=%0b d=%0d want 1 2", iss_valid_o, iss_dest_o);
        end
        drive_disp(OP_SLT, 32'd5, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 4'd3);
        step();
        disp_valid_i = 1'b0;
        n_cmp++;
        if (iss_valid_o !== 1'b1 || iss_dest_o !== 4'd3 || iss_val2_o !== 32'd6) begin
            n_err++; $display("FAIL b2b_second: got v=%0b d=%0d want 1 3", iss_valid_o, iss_dest_o);
        end
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_drain: got %0b want 0", iss_valid_o);
        end
    endtask

    task automatic test_flush();
        iss_ready_i = 1'b0;
        drive_disp(OP_ADD, 32'd8, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 4'd4);
        step();
        drive_disp(OP_ADD, 32'd0, 1'b0, 4'd7, 32'd1, 1'b1, 4'd0, 4'd5);
        flush_i = 1'b1;
        cdb(1'b1, 4'd7, 32'h77);
        step();
        flush_i = 1'b0;
        disp_valid_i = 1'b0;
        cdb(1'b0, 4'd0, 32'd0);
        n_cmp++;
        if (iss_valid_o !== 1'b0 || disp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL flush_clear: got v=%0b r=%0b want 0 1", iss_valid_o, disp_ready_o);
        end
        step();
        n_cmp++;
        if (iss_valid_o !== 1'b0) begin
            n_err++; $display("FAIL flush_nowrite: got %0b want 0", iss_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        iss_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_disp(OP_SRA, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'(i));
            step();
        end
        drive_disp(OP_SRA, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd8);
        iss_ready_i = 1'b1;
        cdb(1'b1, 4'd1, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        disp_valid_i = 1'b0;
        cdb(1'b0, 4'd0, 32'd0);
        n_cmp++;
        if (iss_valid_o !== 1'b0 || disp_ready_o !== 1'b1) begin
            n_err++; $display("FAIL reset_mid: got v=%0b r=%0b want 0 1", iss_valid_o, disp_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_priority();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 4, number of reservation entries (power of 2, 2..8).
REQ-002 SHALL have parameter TAG_W, default oops_structs::ROB_TAG_W (4), width of ROB tags.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, discard all entries (mispredict recovery).
REQ-006 SHALL have ports disp_valid_i (in, 1) and disp_ready_o (out, 1), the dispatch handshake.
REQ-007 SHALL have port disp_inst_i, input, instruction_t, operation for the entry.
REQ-008 SHALL have ports disp_val1_i (in, 32), disp_rdy1_i (in, 1) and disp_tag1_i (in, TAG_W), operand 1 value, valid flag and producer tag.
REQ-009 SHALL have ports disp_val2_i (in, 32), disp_rdy2_i (in, 1) and disp_tag2_i (in, TAG_W), the same for operand 2.
REQ-010 SHALL have port disp_dest_i, input, TAG_W, ROB tag of the result.
REQ-011 SHALL have ports cdb_valid_i (in, 1), cdb_tag_i (in, TAG_W) and cdb_data_i (in, 32), the common data bus snoop.
REQ-012 SHALL have ports iss_valid_o (out, 1) and iss_ready_i (in, 1), the issue handshake toward the alu.
REQ-013 SHALL have ports iss_inst_o (out, instruction_t), iss_val1_o (out, 32), iss_val2_o (out, 32) and iss_dest_o (out, TAG_W), the issued operation, operands and destination tag.

Function
REQ-014 Each entry SHALL be in one of three states: FREE, WAIT (at least one operand pending) or READY (both operands valid).
REQ-015 A dispatch SHALL be accepted on an edge where disp_valid_i=1, disp_ready_o=1 and flush_i=0.
REQ-016 An accepted dispatch SHALL be written into the lowest-index FREE entry.
REQ-017 disp_ready_o SHALL be 1 iff at least one entry is FREE in the current registered state; an entry freed in the same cycle does not count.
REQ-018 While disp_ready_o=0, disp_valid_i SHALL be ignored and no state SHALL change due to dispatch.
REQ-019 Dispatch bypass: if disp_rdyN_i=0, cdb_valid_i=1 and cdb_tag_i=disp_tagN_i in the accept cycle, the entry SHALL capture cdb_data_i and mark operand N valid.
REQ-020 Wakeup: every WAIT entry operand with a tag equal to cdb_tag_i while cdb_valid_i=1 SHALL latch cdb_data_i and become valid at that edge; the entry becomes READY once both operands are valid.
REQ-021 iss_valid_o SHALL be 1 iff some entry is READY in the registered state; there is no combinational path from cdb_* or disp_* to iss_*.
REQ-022 The issued entry SHALL be the lowest-index READY entry; iss_* fields SHALL come from that entry and are don't-care when iss_valid_o=0.
REQ-023 The issued entry SHALL go to FREE on an edge where iss_valid_o=1, iss_ready_i=1 and flush_i=0.
REQ-024 While iss_ready_i=0, the selected entry and iss_* SHALL hold stable unless a lower-index entry becomes READY.
REQ-025 Latency: a dispatch with both operands valid (direct or bypassed) SHALL be issuable in the cycle after acceptance; an operand woken by the CDB in cycle N SHALL be issuable in cycle N+1.
REQ-026 Dispatch, wakeup and issue in the same cycle SHALL all take effect; the freed entry is reusable from the next cycle.
REQ-027 flush_i=1 SHALL set all entries FREE at the edge, overriding any same-cycle dispatch, wakeup or issue.
REQ-028 Operand values and the inst field SHALL pass through unmodified; no arithmetic is performed in this block.

Reset
REQ-029 With rst_i=1 at an edge, all entries SHALL become FREE, so that disp_ready_o=1 and iss_valid_o=0 in the following cycle.
REQ-030 Reset SHALL override flush, dispatch, wakeup and issue, including reset asserted mid-operation.
REQ-031 Entry payload fields need no reset value.

Structure
REQ-032 The rs_entry_t struct (state, inst, val1/2, rdy1/2, tag1/2, dest) and ROB_TAG_W SHALL live in oops_structs.
REQ-033 The lowest-index priority select SHALL be one sub-module, prio_sel, instantiated twice: once for the free-entry select and once for the ready-entry select.

Verification
REQ-034 After reset, dispatch add with val1=5 and val2=7, both ready, dest=3 -> next cycle iss_valid_o=1, iss_val1_o=5, iss_val2_o=7, iss_dest_o=3; with iss_ready_i=1, iss_valid_o=0 the cycle after.
REQ-035 Dispatch sub with op1 pending on tag 2, then CDB tag=2 data=0x10 two cycles later -> iss_valid_o rises exactly one cycle after the CDB beat with iss_val1_o=0x10.
REQ-036 Dispatch with op2 pending on tag 6 while CDB tag=6 data=0xAB in the same cycle -> issuable next cycle with iss_val2_o=0xAB.
REQ-037 Fill 4 entries with iss_ready_i=0 -> disp_ready_o=0, a fifth disp_valid_i is ignored; one issue handshake -> disp_ready_o=1 the next cycle.
REQ-038 With entries 0 and 2 READY and iss_ready_i=1 -> entry 0 issues before entry 2, and iss_* is stable while iss_ready_i=0.
REQ-039 Assert flush_i together with a dispatch and a CDB match -> next cycle iss_valid_o=0, disp_ready_o=1, and no entry is written.
